// File: rtl/cic_decimator_nstage.sv
// N-stage CIC decimator: gated integrators, runtime ratio, comb pipe with
// differential delay, gain shift with saturation, ready/valid output register.
module cic_decimator_nstage #(
    parameter int DATA_WIDTH     = 12,
    parameter int STAGES         = 5,
    parameter int MAX_DECIMATION = 4096,
    parameter int DIFF_DELAY     = 1,
    parameter int GAIN_WIDTH     = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    input  logic [DATA_WIDTH-1:0]             data_in,
    input  logic [$clog2(MAX_DECIMATION):0]   decimation,
    input  logic [GAIN_WIDTH-1:0]             gain,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_WIDTH-1:0]             data_out,
    output logic                              saturated,
    output logic                              overrun
);
    localparam int CW        = $clog2(MAX_DECIMATION) + 1;
    localparam int REG_W     = DATA_WIDTH + STAGES * $clog2(MAX_DECIMATION * DIFF_DELAY);
    localparam int SHIFT_MAX = REG_W - DATA_WIDTH;
    localparam int SW        = $clog2(SHIFT_MAX + 1);
    localparam logic signed [REG_W-1:0] SAT_HI = {{(REG_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [REG_W-1:0] SAT_LO = {{(REG_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic [1:0]            rst_sync_q;
    logic                  rst_int_n;
    logic [CW-1:0]         dec_clamped, act_ratio;
    logic [CW-1:0]         cnt_q, cnt_d, ratio_q, ratio_d;
    logic                  ratio_vld_q, ratio_vld_d;
    logic                  last_in;
    logic [REG_W-1:0]      integ_q [STAGES];
    logic [REG_W-1:0]      comb_q  [STAGES+1];   // comb_q[0] is the captured I_N
    logic [REG_W-1:0]      dly_q   [STAGES][DIFF_DELAY];
    logic [STAGES:0]       vld_pipe_q;
    logic [SW-1:0]         shamt;
    logic signed [REG_W-1:0] shifted;
    logic [DATA_WIDTH-1:0] sat_val;
    logic                  clip, load, free;
    logic                  out_valid_q, saturated_q, overrun_q;
    logic [DATA_WIDTH-1:0] data_out_q;

    // Reset synchroniser: assertion passes straight through, release is aligned to clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    // Clamp the requested ratio into [2, MAX_DECIMATION]
    always_comb begin
        dec_clamped = decimation;
        if (decimation < CW'(2))                   dec_clamped = CW'(2);
        else if (decimation > CW'(MAX_DECIMATION)) dec_clamped = CW'(MAX_DECIMATION);
    end

    // Until the first accepted input the port value is live, so the ratio
    // present around reset defines the first period without an async data load.
    assign act_ratio = ratio_vld_q ? ratio_q : dec_clamped;
    assign last_in   = (cnt_q == act_ratio - CW'(1));

    // Counter/ratio next state: ratio is re-sampled only at a period boundary
    always_comb begin
        cnt_d       = cnt_q;
        ratio_d     = ratio_q;
        ratio_vld_d = ratio_vld_q;
        if (in_valid) begin
            ratio_vld_d = 1'b1;
            if (last_in) begin
                cnt_d   = '0;
                ratio_d = dec_clamped;
            end else begin
                cnt_d = cnt_q + CW'(1);
                if (!ratio_vld_q) ratio_d = dec_clamped;
            end
        end
    end

    // Decimation counter and active ratio registers
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            cnt_q       <= '0;
            ratio_q     <= CW'(2);
            ratio_vld_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            ratio_q     <= ratio_d;
            ratio_vld_q <= ratio_vld_d;
        end
    end

    // Integrator cascade; each stage adds the previous stage's pre-update value, wrapping freely
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            for (int k = 0; k < STAGES; k++) integ_q[k] <= '0;
        end else if (in_valid) begin
            integ_q[0] <= integ_q[0] + {{(REG_W-DATA_WIDTH){data_in[DATA_WIDTH-1]}}, data_in};
            for (int k = 1; k < STAGES; k++) integ_q[k] <= integ_q[k] + integ_q[k-1];
        end
    end

    // Capture I_N at the boundary, then one comb stage per clock behind a token shift register
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            vld_pipe_q <= '0;
            for (int k = 0; k <= STAGES; k++) comb_q[k] <= '0;
            for (int k = 0; k < STAGES; k++)
                for (int d = 0; d < DIFF_DELAY; d++) dly_q[k][d] <= '0;
        end else begin
            vld_pipe_q[0] <= in_valid && last_in;
            if (in_valid && last_in) comb_q[0] <= integ_q[STAGES-1];
            for (int k = 1; k <= STAGES; k++) begin
                vld_pipe_q[k] <= vld_pipe_q[k-1];
                if (vld_pipe_q[k-1]) begin
                    comb_q[k]     <= comb_q[k-1] - dly_q[k-1][DIFF_DELAY-1];
                    dly_q[k-1][0] <= comb_q[k-1];
                    for (int d = 1; d < DIFF_DELAY; d++) dly_q[k-1][d] <= dly_q[k-1][d-1];
                end
            end
        end
    end

    // Gain-controlled arithmetic shift followed by saturation to the output width
    always_comb begin
        if (int'(gain) >= SHIFT_MAX) shamt = '0;
        else                         shamt = SW'(SHIFT_MAX - int'(gain));
        shifted = $signed(comb_q[STAGES]) >>> shamt;
        clip    = 1'b1;
        if (shifted > SAT_HI)      sat_val = SAT_HI[DATA_WIDTH-1:0];
        else if (shifted < SAT_LO) sat_val = SAT_LO[DATA_WIDTH-1:0];
        else begin
            sat_val = shifted[DATA_WIDTH-1:0];
            clip    = 1'b0;
        end
    end

    assign load = vld_pipe_q[STAGES];
    assign free = !out_valid_q || out_ready;

    // Output register: load when empty or draining, otherwise drop the result and flag overrun
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            saturated_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            saturated_q <= load && free && clip;
            if (load && free) begin
                out_valid_q <= 1'b1;
                data_out_q  <= sat_val;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (load && !free) overrun_q <= 1'b1;
        end
    end

    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;
    assign saturated = saturated_q;
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_cic_decimator_nstage.sv
// Scoreboard bench for cic_decimator_nstage: stimulus pushes expected outputs,
// a monitor pops and compares on every accepted output.
module tb_cic_decimator_nstage;
    localparam int DW = 12;
    localparam int GW = 8;
    localparam int CW = 13;

    logic          clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic          out_valid, saturated, overrun;
    logic [DW-1:0] data_in = '0, data_out;
    logic [CW-1:0] decimation = 13'd16;
    logic [GW-1:0] gain = 8'd40;
    int            checks = 0, errors = 0, cyc = 0;

    typedef struct { bit chk; int val; bit sat; int sp; } exp_t;
    exp_t sb_q[$];

    cic_decimator_nstage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data_in(data_in),
        .decimation(decimation), .gain(gain), .out_valid(out_valid),
        .out_ready(out_ready), .data_out(data_out), .saturated(saturated),
        .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // chk=0 entries are settling outputs: only their presence and spacing are checked
    task automatic push(input bit chk, input int val, input bit sat, input int sp);
        exp_t e;
        e.chk = chk; e.val = val; e.sat = sat; e.sp = sp;
        sb_q.push_back(e);
    endtask

    task automatic push_settling(input int sp);
        push(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) push(0, 0, 0, sp);
    endtask

    task automatic do_reset(input int dec, input int g);
        decimation = CW'(dec);
        gain       = GW'(g);
        in_valid   = 1'b0;
        rst_n      = 1'b0;
        sb_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    // One input per clock (or every other clock when gated); called just after a posedge
    task automatic feed(input int n, input int x, input bit gated);
        logic [31:0] xv;
        xv = x;
        for (int i = 0; i < n; i++) begin
            data_in  = xv[DW-1:0];
            in_valid = 1'b1;
            @(posedge clk); #1;
            if (gated) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d expected outputs never arrived", name, sb_q.size());
            sb_q.delete();
        end
        repeat (20) @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted output must match the head of the scoreboard
    initial begin : monitor
        exp_t e;
        int   last_cyc;
        last_cyc = 0;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: data_out=%0d with nothing expected", $signed(data_out));
                end else begin
                    e = sb_q.pop_front();
                    if (e.chk) begin
                        check("out_data", $signed(data_out), e.val);
                        check("out_saturated", int'(saturated), int'(e.sat));
                    end
                    if (e.sp != 0) check("out_spacing", cyc - last_cyc, e.sp);
                    last_cyc = cyc;
                end
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int stale, changed, n;
        logic [DW-1:0] held;

        // Reset state
        do_reset(16, 40);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_data_out", int'(data_out), 0);
        check("rst_saturated", int'(saturated), 0);
        check("rst_overrun", int'(overrun), 0);

        // DC 100, R=16, gain 40: (R*M)^N = 2^20 and shift 20 give unity gain
        do_reset(16, 40);
        push_settling(16);
        for (int i = 0; i < 4; i++) push(1, 100, 0, 16);
        feed(9 * 16, 100, 0);
        drain("dc");

        // Same with in_valid toggling: same values, twice the spacing
        do_reset(16, 40);
        push_settling(32);
        for (int i = 0; i < 4; i++) push(1, 100, 0, 32);
        feed(9 * 16, 100, 1);
        drain("gated");

        // Saturation: 1500 scaled by 2 is 3000, clipped to 2047 / -2048
        do_reset(16, 41);
        push_settling(16);
        for (int i = 0; i < 4; i++) push(1, 2047, 1, 16);
        feed(9 * 16, 1500, 0);
        drain("sat_pos");
        do_reset(16, 41);
        push_settling(16);
        for (int i = 0; i < 4; i++) push(1, -2048, 1, 16);
        feed(9 * 16, -1500, 0);
        drain("sat_neg");

        // Ratio 16 -> 8 requested mid-period: that period still spans 16 inputs
        do_reset(16, 40);
        push(0, 0, 0, 0);
        push(0, 0, 0, 16);
        for (int i = 0; i < 3; i++) push(0, 0, 0, 8);
        feed(24, 100, 0);
        decimation = 13'd8;
        feed(32, 100, 0);
        drain("ratio_change");

        // decimation=1 behaves as R=2
        do_reset(1, 40);
        push(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) push(0, 0, 0, 2);
        feed(10, 100, 0);
        drain("ratio_low");

        // Largest encodable request above the maximum behaves as R=4096
        do_reset(13'h1FFF, 60);
        push(0, 0, 0, 0);
        push(0, 0, 0, 4096);
        feed(8192, 100, 0);
        drain("ratio_high");

        // Backpressure: first result is 3003*1000 >>> 20 = 2, held for 40 clocks;
        // the 2nd and 3rd results are dropped, then results 4.. flow
        do_reset(16, 40);
        out_ready = 1'b0;
        push(1, 2, 0, 0);
        push(0, 0, 0, 0);
        push(0, 0, 0, 16);
        push(1, 1000, 0, 16);
        push(1, 1000, 0, 16);
        changed = 0;
        fork
            feed(7 * 16, 1000, 0);
            begin
                n = 0;
                while (!out_valid && n < 100) begin
                    @(posedge clk); #1;
                    n++;
                end
                check("bp_first_valid", int'(out_valid), 1);
                held = data_out;
                repeat (40) begin
                    @(posedge clk); #1;
                    if (data_out !== held || out_valid !== 1'b1) changed++;
                end
                check("bp_held_stable", changed, 0);
                check("bp_held_value", $signed(data_out), 2);
                check("bp_overrun_set", int'(overrun), 1);
                out_ready = 1'b1;
            end
        join
        drain("backpressure");
        check("bp_overrun_sticky", int'(overrun), 1);

        // Asynchronous reset between clock edges while a result is held
        out_ready = 1'b0;
        fork
            feed(40, 500, 0);
            begin
                repeat (30) @(posedge clk);
                #3;
                check("pre_reset_valid", int'(out_valid), 1);
                rst_n = 1'b0;
                sb_q.delete();
                #1;
                check("async_rst_valid", int'(out_valid), 0);
                check("async_rst_data", int'(data_out), 0);
                check("async_rst_overrun", int'(overrun), 0);
                check("async_rst_saturated", int'(saturated), 0);
            end
        join
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_valid) stale++;
        end
        check("no_stale_valid", stale, 0);
        check("post_rst_overrun", int'(overrun), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
